// File: rtl/jk_counter_reg.sv
// jk_counter_reg: parametrised multi-bit JK register and synchronous modulo counter.
// Register mode applies JK next-state semantics to each bit independently.
// Counter mode counts the whole word up or down modulo MODULUS, with a
// combinational terminal-count flag that can be chained as the next stage's en.
// Optional parallel load is enabled by defining JK_COUNTER_REG_LOAD_EN.
module jk_counter_reg #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             up,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
`ifdef JK_COUNTER_REG_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc
);

    // Last legal count, kept one bit wider than the state so that
    // MODULUS = 2^WIDTH still compares correctly.
    localparam int               LAST_INT = MODULUS - 1;
    localparam logic [WIDTH:0]   LAST_EXT = LAST_INT[WIDTH:0];
    localparam logic [WIDTH-1:0] LAST_W   = LAST_INT[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] down_next;
    logic             load_i;
    logic [WIDTH-1:0] d_i;

`ifdef JK_COUNTER_REG_LOAD_EN
    assign load_i = load;
    assign d_i    = D;
`else
    assign load_i = 1'b0;
    assign d_i    = '0;
`endif

    // Candidate next states for register mode and both counting directions.
    // Any state at or beyond the last count wraps to 0 going up, and any
    // out-of-range state snaps to the last count going down.
    always_comb begin
        q_ext     = {1'b0, q_q};
        jk_next   = (J & ~q_q) | (~K & q_q);
        up_next   = '0;
        down_next = LAST_W;
        if (q_ext < LAST_EXT) begin
            up_next = q_q + 1'b1;
        end
        if ((q_ext != '0) && (q_ext <= LAST_EXT)) begin
            down_next = q_q - 1'b1;
        end
    end

    // Next-state selection: load beats enable, enable beats hold.
    // Reset is applied in the state register itself.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (en) begin
            if (mode) begin
                q_d = up ? up_next : down_next;
            end else begin
                q_d = jk_next;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal count flags the cycle before a wrapping edge; forced low
    // whenever reset or load will override the count.
    always_comb begin
        tc = 1'b0;
        if (mode && en && !reset && !load_i) begin
            tc = up ? (q_ext == LAST_EXT) : (q_ext == '0);
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Testbench for jk_counter_reg (WIDTH=4, MODULUS=10): directed scenarios
// followed by randomized stimulus against a behavioural model.
module tb_jk_counter_reg;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset, en, mode, up, load;
    logic [W-1:0] J, K, D;
    logic [W-1:0] Q, Qbar;
    logic         tc;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    jk_counter_reg #(.WIDTH(W), .MODULUS(M)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .up    (up),
        .J     (J),
        .K     (K),
`ifdef JK_COUNTER_REG_LOAD_EN
        .load  (load),
        .D     (D),
`endif
        .Q     (Q),
        .Qbar  (Qbar),
        .tc    (tc)
    );

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; en = 1'b0; mode = 1'b0; up = 1'b0;
        J = '0; K = '0; load = 1'b0; D = '0;
    endtask

    // Behavioural model of the next state, written from the operating rules.
    function automatic int model_next(int q, bit r, bit ld, int d, bit e, bit md, bit u,
                                      logic [W-1:0] j, logic [W-1:0] k);
        int n;
        if (r) return 0;
        if (ld) return d;
        if (!e) return q;
        if (md) begin
            if (u) return (q >= M - 1) ? 0 : q + 1;
            return (q == 0 || q >= M) ? M - 1 : q - 1;
        end
        n = 0;
        for (int i = 0; i < W; i++) begin
            int b;
            b = (q >> i) & 1;
            case ({j[i], k[i]})
                2'b00: ;
                2'b01: b = 0;
                2'b10: b = 1;
                default: b = 1 - b;
            endcase
            n = n + (b << i);
        end
        return n;
    endfunction

    function automatic bit model_tc(int q, bit r, bit ld, bit e, bit md, bit u);
        if (r || ld || !e || !md) return 1'b0;
        return u ? (q == M - 1) : (q == 0);
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; en = 1'b1; mode = 1'b1; up = 1'b1; J = '1; K = '1;
        #1;
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_tc_pre: got %b want 0", tc);
        end
        tick();
        tick();
        n_compared++;
        if (Q !== 4'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_q: got %h want 0", Q);
        end
        n_compared++;
        if (Qbar !== 4'hF) begin
            n_mismatched++;
            $display("[TB] FAIL reset_qbar: got %h want f", Qbar);
        end
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_tc: got %b want 0", tc);
        end
        idle_inputs();
    endtask

    task automatic test_register();
        logic [W-1:0] js [4] = '{4'b1010, 4'b1111, 4'b0000, 4'b1111};
        logic [W-1:0] ks [4] = '{4'b0000, 4'b1111, 4'b0100, 4'b0000};
        logic         es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] exp [4] = '{4'b1010, 4'b0101, 4'b0001, 4'b0001};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mode = 1'b0; en = es[i]; J = js[i]; K = ks[i];
            tick();
            n_compared++;
            if (Q !== exp[i] || Qbar !== ~exp[i]) begin
                n_mismatched++;
                $display("[TB] FAIL register_step%0d: got Q=%b Qbar=%b want Q=%b", i, Q, Qbar, exp[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_count_up();
        int cur;
        do_reset();
        mode = 1'b1; up = 1'b1; en = 1'b1;
        cur = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            n_compared++;
            if (tc !== (cur == 9)) begin
                n_mismatched++;
                $display("[TB] FAIL count_up_tc: Q=%0d got tc=%b want %b", cur, tc, cur == 9);
            end
            tick();
            cur = i % 10;
            n_compared++;
            if (Q !== cur[W-1:0]) begin
                n_mismatched++;
                $display("[TB] FAIL count_up_q: got %0d want %0d", Q, cur);
            end
        end
        idle_inputs();
    endtask

    task automatic test_count_down();
        int cur;
        do_reset();
        mode = 1'b1; up = 1'b0; en = 1'b1;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_compared++;
            if (tc !== (cur == 0)) begin
                n_mismatched++;
                $display("[TB] FAIL count_down_tc: Q=%0d got tc=%b want %b", cur, tc, cur == 0);
            end
            tick();
            cur = (cur == 0) ? 9 : cur - 1;
            n_compared++;
            if (Q !== cur[W-1:0]) begin
                n_mismatched++;
                $display("[TB] FAIL count_down_q: got %0d want %0d", Q, cur);
            end
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        do_reset();
        en = 1'b1; mode = 1'b0; J = 4'b1111; K = 4'b0000;
        tick();
        mode = 1'b1; up = 1'b1;
        #1;
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL oor_up_tc: got %b want 0", tc);
        end
        tick();
        n_compared++;
        if (Q !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL oor_up: got %0d want 0", Q);
        end
        mode = 1'b0; J = 4'b1100; K = 4'b0011;
        tick();
        mode = 1'b1; up = 1'b0;
        #1;
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL oor_down_tc: got %b want 0", tc);
        end
        tick();
        n_compared++;
        if (Q !== 4'd9) begin
            n_mismatched++;
            $display("[TB] FAIL oor_down: got %0d want 9", Q);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midcount();
        do_reset();
        mode = 1'b1; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_compared++;
        if (Q !== 4'd5) begin
            n_mismatched++;
            $display("[TB] FAIL midcount_pre: got %0d want 5", Q);
        end
        reset = 1'b1;
        tick();
        n_compared++;
        if (Q !== 4'd0 || Qbar !== 4'hF) begin
            n_mismatched++;
            $display("[TB] FAIL midcount_reset: got Q=%0d Qbar=%h want 0/f", Q, Qbar);
        end
        reset = 1'b0;
        tick();
        n_compared++;
        if (Q !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL midcount_resume: got %0d want 1", Q);
        end
        idle_inputs();
    endtask

`ifdef JK_COUNTER_REG_LOAD_EN
    task automatic test_load();
        do_reset();
        load = 1'b1; D = 4'd7; en = 1'b0;
        tick();
        n_compared++;
        if (Q !== 4'd7) begin
            n_mismatched++;
            $display("[TB] FAIL load_basic: got %0d want 7", Q);
        end
        reset = 1'b1; D = 4'd5;
        tick();
        n_compared++;
        if (Q !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL load_vs_reset: got %0d want 0", Q);
        end
        reset = 1'b0; load = 1'b1; D = 4'd14; en = 1'b1; mode = 1'b1; up = 1'b0;
        #1;
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL load_tc: got %b want 0", tc);
        end
        tick();
        load = 1'b0; up = 1'b1;
        tick();
        n_compared++;
        if (Q !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL load_oor_up: got %0d want 0", Q);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        int q_model;
        bit exp_tc;
        do_reset();
        q_model = 0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = $urandom_range(0, 1);
            up    = $urandom_range(0, 1);
            J     = W'($urandom_range(0, 15));
            K     = W'($urandom_range(0, 15));
`ifdef JK_COUNTER_REG_LOAD_EN
            load  = ($urandom_range(0, 7) == 0);
`else
            load  = 1'b0;
`endif
            D     = W'($urandom_range(0, 15));
            #1;
            exp_tc = model_tc(q_model, reset, load, en, mode, up);
            n_compared++;
            if (tc !== exp_tc) begin
                n_mismatched++;
                $display("[TB] FAIL random_tc cycle %0d: got %b want %b", i, tc, exp_tc);
            end
            q_model = model_next(q_model, reset, load, int'(D), en, mode, up, J, K);
            tick();
            n_compared++;
            if (Q !== q_model[W-1:0] || Qbar !== ~q_model[W-1:0]) begin
                n_mismatched++;
                $display("[TB] FAIL random_q cycle %0d: got Q=%0d Qbar=%h want Q=%0d", i, Q, Qbar, q_model);
                q_model = int'(Q);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_register();
        test_count_up();
        test_count_down();
        test_out_of_range();
        test_reset_midcount();
`ifdef JK_COUNTER_REG_LOAD_EN
        test_load();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/jk_counter_reg.md
# jk_counter_reg

Parametrised multi-bit JK register and synchronous modulo counter for the lab datapath. Each bit follows JK flip-flop next-state semantics in register mode. In counter mode the whole word counts up or down with wrap-around and a terminal-count flag. It is the vector, counter-capable generation of the single-bit JK flip-flop. It sits wherever the design needs a settable/togglable state word or a small cycle counter.

## Interface
Parameters:
- `WIDTH`, 4: bits in the state word; legal range 1..16.
- `MODULUS`, 16: counter-mode modulus; counter range is 0..MODULUS-1; legal range 2..2^WIDTH.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `en`  input  1  update enable; when 0, state holds.
- `mode`  input  1  0 = JK register mode, 1 = counter mode.
- `up`  input  1  counter direction: 1 = up, 0 = down. Ignored in register mode.
- `J`  input  WIDTH  per-bit J inputs. Register mode only.
- `K`  input  WIDTH  per-bit K inputs. Register mode only.
- `Q`  output  WIDTH  state word.
- `Qbar`  output  WIDTH  bitwise complement of `Q`.
- `tc`  output  1  terminal count, combinational from state and inputs.
- `load`  input  1  parallel load strobe. Present only with `JK_COUNTER_REG_LOAD_EN`.
- `D`  input  WIDTH  parallel load data. Present only with `JK_COUNTER_REG_LOAD_EN`.

## Operation
- Update priority, evaluated at each rising `clk`: `reset` > `load` > `en` > hold.
- `reset`: Q = 0 and Qbar = all ones. This overrides every other input in the same cycle.
- Register mode (`mode`=0, `en`=1): per bit i, Q[i]_next = (J[i] & ~Q[i]) | (~K[i] & Q[i]).
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- Counter mode (`mode`=1, `en`=1), counting up:
  - Q == MODULUS-1 → 0.
  - Otherwise Q+1.
- Counter mode (`mode`=1, `en`=1), counting down:
  - Q == 0 → MODULUS-1.
  - Otherwise Q-1.
- Out-of-range state (Q ≥ MODULUS, reachable via register mode or load) on entering counter mode:
  - Up: next Q = 0.
  - Down: next Q = MODULUS-1.
  - This is never undefined.
- Arithmetic is done at WIDTH+1 bits internally. There is no overflow outside the wrap rules above.
- `mode` and `up` may change on any cycle. The new value applies at the next edge, with no pipeline bubble.
- `tc` = `mode` & `en` & ((`up` & Q==MODULUS-1) | (~`up` & Q==0)).
  - `tc` is 0 whenever `reset` is high.
  - `tc` is 0 whenever `load` is high (load build).
- `Qbar` is exactly ~`Q` at all times, including the reset value.

## Timing
- Latency: 1 cycle from input sampling to new `Q`/`Qbar`.
- `tc` is combinational. It is valid in the cycle before the wrapping edge, so it can be chained as the `en` of a following stage.
- Reset values: `Q` = 0, `Qbar` = 2^WIDTH-1, `tc` = 0.
- Reset mid-count: `Q` = 0 on the edge where `reset` is sampled high. Counting resumes from 0 on the first edge after `reset` falls, if `en`=1.
- Before the first reset, output state is undefined. The bench must apply reset first.

## Configuration
- Macro: `JK_COUNTER_REG_LOAD_EN`.
- Defined:
  - Ports `load` and `D` exist.
  - `load`=1 sets Q = D at the next edge, regardless of `en` and `mode`.
  - D ≥ MODULUS is stored as-is and then follows the out-of-range rule.
- Undefined:
  - `load` and `D` are absent.
  - Priority reduces to `reset` > `en` > hold.
  - All other behaviour is identical.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `en`=1, J=K=all ones → Q=0, Qbar=all ones, tc=0.
- Register mode, WIDTH=4, from Q=0: J=4'b1010, K=4'b0000 → Q=4'b1010. Then J=K=4'b1111 → Q=4'b0101. Then J=0, K=4'b0100 → Q=4'b0001. Then `en`=0 → Q holds 4'b0001.
- Counter up, MODULUS=10: reset, then `mode`=1, `up`=1, `en`=1 for 12 cycles → sequence 1..9, 0, 1, 2. tc=1 only while Q=9.
- Counter down, MODULUS=10, from 0 → 9, 8, …. tc=1 while Q=0. Out-of-range entry: set Q=4'b1111 in register mode, switch to `up` counting → next Q=0. Switch to down counting from 4'b1100 → next Q=9.
- Reset mid-count: assert `reset` when Q=5 with `en`=1 → Q=0 on that edge. After release → 1.
- Load build only: `load`=1, D=7, `en`=0 → Q=7. Then `load`=1 together with `reset`=1 → Q=0.
